// File: rtl/bloco_pkg.sv
// Shared types and constants for the multicycle register-bank/ALU block.
package bloco_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_PASSA = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_NOT   = 5'd6,
    OP_SHL   = 5'd7,
    OP_SHR   = 5'd8,
    OP_LDI   = 5'd9
  } opcode_t;

  typedef enum logic [1:0] {
    OCIOSO,
    LEITURA,
    EXECUCAO,
    ESCRITA
  } estado_t;

  // Bit positions inside flags = {Z,N,C,V}
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/bloco_multiciclo_if.sv
// Command/status bundle between a requester and bloco_multiciclo.
interface bloco_multiciclo_if #(
  parameter int unsigned bits_palavra  = 16,
  parameter int unsigned end_registros = 3
);
  import bloco_pkg::*;

  logic                     inicio;
  logic [OP_W-1:0]          controleOperacao;
  logic [end_registros-1:0] Sel_SA;
  logic [end_registros-1:0] Sel_SB;
  logic [end_registros-1:0] Sel_SC;
  logic                     Hab_Escrita;
  logic [bits_palavra-1:0]  imediato;
  logic                     ocupado;
  logic                     pronto;
  logic [bits_palavra-1:0]  resultado;
  logic [FLAGS_W-1:0]       flags;
  logic                     erro_op;

  modport master (
    output inicio, controleOperacao, Sel_SA, Sel_SB, Sel_SC, Hab_Escrita, imediato,
    input  ocupado, pronto, resultado, flags, erro_op
  );

  modport slave (
    input  inicio, controleOperacao, Sel_SA, Sel_SB, Sel_SC, Hab_Escrita, imediato,
    output ocupado, pronto, resultado, flags, erro_op
  );

endinterface

// File: rtl/ula_param.sv
// Combinational ALU: result, {Z,N,C,V} and a valid bit for defined opcodes.
module ula_param
  import bloco_pkg::*;
#(
  parameter int unsigned bits_palavra = 16
) (
  input  logic [OP_W-1:0]         op,
  input  logic [bits_palavra-1:0] a,
  input  logic [bits_palavra-1:0] b,
  input  logic [bits_palavra-1:0] imediato,
  output logic [bits_palavra-1:0] resultado,
  output logic [FLAGS_W-1:0]      flags,
  output logic                    valido
);

  localparam int unsigned MSB = bits_palavra - 1;

  logic [bits_palavra:0] soma;
  logic [bits_palavra:0] dif;
  logic                  c;
  logic                  v;

  // Extra top bit holds carry for ADD and borrow for SUB
  assign soma = {1'b0, a} + {1'b0, b};
  assign dif  = {1'b0, a} - {1'b0, b};

  always_comb begin
    resultado = '0;
    valido    = 1'b1;
    c         = 1'b0;
    v         = 1'b0;
    case (op)
      OP_PASSA: resultado = a;
      OP_ADD: begin
        resultado = soma[MSB:0];
        c         = soma[bits_palavra];
        v         = (a[MSB] == b[MSB]) && (soma[MSB] != a[MSB]);
      end
      OP_SUB: begin
        resultado = dif[MSB:0];
        c         = dif[bits_palavra];
        v         = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
      end
      OP_AND:   resultado = a & b;
      OP_OR:    resultado = a | b;
      OP_XOR:   resultado = a ^ b;
      OP_NOT:   resultado = ~a;
      OP_SHL: begin
        resultado = {a[MSB-1:0], 1'b0};
        c         = a[MSB];
      end
      OP_SHR: begin
        resultado = {1'b0, a[MSB:1]};
        c         = a[0];
      end
      OP_LDI:   resultado = imediato;
      default:  valido = 1'b0;
    endcase
    flags         = '0;
    flags[FLAG_Z] = (resultado == '0);
    flags[FLAG_N] = resultado[MSB];
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/bloco_multiciclo.sv
// Four-state multicycle datapath: capture, read bank, execute ALU, write back.
module bloco_multiciclo
  import bloco_pkg::*;
#(
  parameter int unsigned bits_palavra  = 16,
  parameter int unsigned end_registros = 3
) (
  input logic              clk,
  input logic              reset,
  bloco_multiciclo_if.slave bus
);

  localparam int unsigned NUM_REGS = 2 ** end_registros;

  estado_t                  estado;
  logic [OP_W-1:0]          op_q;
  logic [end_registros-1:0] sel_a_q;
  logic [end_registros-1:0] sel_b_q;
  logic [end_registros-1:0] sel_c_q;
  logic                     hab_q;
  logic [bits_palavra-1:0]  imm_q;
  logic [bits_palavra-1:0]  a_q;
  logic [bits_palavra-1:0]  b_q;
  logic                     op_valido_q;
  logic [bits_palavra-1:0]  resultado_q;
  logic [FLAGS_W-1:0]       flags_q;
  logic                     ocupado_q;
  logic                     pronto_q;
  logic                     erro_q;
  logic [bits_palavra-1:0]  banco [NUM_REGS];

  logic [bits_palavra-1:0]  ula_res;
  logic [FLAGS_W-1:0]       ula_flags;
  logic                     ula_valido;

  ula_param #(.bits_palavra(bits_palavra)) u_ula (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .imediato  (imm_q),
    .resultado (ula_res),
    .flags     (ula_flags),
    .valido    (ula_valido)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      op_q        <= '0;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      sel_c_q     <= '0;
      hab_q       <= 1'b0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_valido_q <= 1'b0;
      resultado_q <= '0;
      flags_q     <= '0;
      ocupado_q   <= 1'b0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) banco[i] <= '0;
    end else begin
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.inicio) begin
            op_q      <= bus.controleOperacao;
            sel_a_q   <= bus.Sel_SA;
            sel_b_q   <= bus.Sel_SB;
            sel_c_q   <= bus.Sel_SC;
            hab_q     <= bus.Hab_Escrita;
            imm_q     <= bus.imediato;
            ocupado_q <= 1'b1;
            estado    <= LEITURA;
          end
        end
        LEITURA: begin
          a_q    <= banco[sel_a_q];
          b_q    <= banco[sel_b_q];
          estado <= EXECUCAO;
        end
        EXECUCAO: begin
          // Undefined opcodes keep the previous result and flags
          if (ula_valido) begin
            resultado_q <= ula_res;
            flags_q     <= ula_flags;
          end
          op_valido_q <= ula_valido;
          estado      <= ESCRITA;
        end
        ESCRITA: begin
          if (hab_q && op_valido_q) banco[sel_c_q] <= resultado_q;
          pronto_q  <= 1'b1;
          erro_q    <= ~op_valido_q;
          ocupado_q <= 1'b0;
          estado    <= OCIOSO;
        end
        default: begin
          ocupado_q <= 1'b0;
          estado    <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.ocupado   = ocupado_q;
  assign bus.pronto    = pronto_q;
  assign bus.resultado = resultado_q;
  assign bus.flags     = flags_q;
  assign bus.erro_op   = erro_q;

endmodule

// File: tb/tb_bloco_multiciclo.sv
// Directed bench for bloco_multiciclo (16-bit words, 8 registers).
module tb_bloco_multiciclo;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  bloco_multiciclo_if #(.bits_palavra(16), .end_registros(3)) bus ();

  bloco_multiciclo #(.bits_palavra(16), .end_registros(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and watch a bounded window for its completion pulse
  task automatic run_op(input logic [4:0] op, input logic [2:0] sa, input logic [2:0] sb,
                        input logic [2:0] sc, input logic hab, input logic [15:0] imm,
                        output int lat, output int npr, output logic [15:0] res,
                        output logic [3:0] flg, output logic err);
    @(negedge clk);
    bus.controleOperacao = op;
    bus.Sel_SA = sa; bus.Sel_SB = sb; bus.Sel_SC = sc;
    bus.Hab_Escrita = hab; bus.imediato = imm;
    bus.inicio = 1'b1;
    @(posedge clk);
    #1 bus.inicio = 1'b0;
    bus.controleOperacao = 5'd6; bus.Sel_SA = ~sa; bus.Sel_SC = ~sc; bus.imediato = ~imm;
    lat = -1; npr = 0; res = '0; flg = '0; err = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.pronto) begin
        npr++;
        if (lat < 0) begin
          lat = i; res = bus.resultado; flg = bus.flags; err = bus.erro_op;
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.ocupado !== 1'b0) $display("FAIL reset_ocupado got=%b exp=0", bus.ocupado); else passed++;
    checks++; if (bus.pronto !== 1'b0) $display("FAIL reset_pronto got=%b exp=0", bus.pronto); else passed++;
    checks++; if (bus.erro_op !== 1'b0) $display("FAIL reset_erro got=%b exp=0", bus.erro_op); else passed++;
    checks++; if (bus.resultado !== 16'h0000) $display("FAIL reset_resultado got=%h exp=0000", bus.resultado); else passed++;
    checks++; if (bus.flags !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", bus.flags); else passed++;
  endtask

  task automatic test_ldi_add();
    int lat, npr; logic [15:0] res; logic [3:0] flg; logic err;
    run_op(5'd9, 3'd0, 3'd0, 3'd1, 1'b1, 16'h7FFF, lat, npr, res, flg, err);
    checks++; if (lat !== 4) $display("FAIL ldi1_latency got=%0d exp=4", lat); else passed++;
    checks++; if (res !== 16'h7FFF) $display("FAIL ldi1_res got=%h exp=7fff", res); else passed++;
    run_op(5'd9, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0001, lat, npr, res, flg, err);
    checks++; if (lat !== 4) $display("FAIL ldi2_latency got=%0d exp=4", lat); else passed++;
    checks++; if (res !== 16'h0001) $display("FAIL ldi2_res got=%h exp=0001", res); else passed++;
    run_op(5'd1, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0000, lat, npr, res, flg, err);
    checks++; if (lat !== 4) $display("FAIL add_latency got=%0d exp=4", lat); else passed++;
    checks++; if (npr !== 1) $display("FAIL add_pronto_width got=%0d exp=1", npr); else passed++;
    checks++; if (res !== 16'h8000) $display("FAIL add_res got=%h exp=8000", res); else passed++;
    checks++; if (flg !== 4'b0101) $display("FAIL add_flags got=%b exp=0101", flg); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL add_erro got=%b exp=0", err); else passed++;
  endtask

  task automatic test_sub_shl();
    int lat, npr; logic [15:0] res; logic [3:0] flg; logic err;
    run_op(5'd2, 3'd2, 3'd2, 3'd4, 1'b1, 16'h0000, lat, npr, res, flg, err);
    checks++; if (res !== 16'h0000) $display("FAIL sub_res got=%h exp=0000", res); else passed++;
    checks++; if (flg !== 4'b1000) $display("FAIL sub_flags got=%b exp=1000", flg); else passed++;
    run_op(5'd7, 3'd3, 3'd0, 3'd0, 1'b0, 16'h0000, lat, npr, res, flg, err);
    checks++; if (res !== 16'h0000) $display("FAIL shl_res got=%h exp=0000", res); else passed++;
    checks++; if (flg !== 4'b1010) $display("FAIL shl_flags got=%b exp=1010", flg); else passed++;
  endtask

  task automatic test_hab_escrita();
    int lat, npr; logic [15:0] res; logic [3:0] flg; logic err;
    run_op(5'd1, 3'd1, 3'd2, 3'd5, 1'b0, 16'h0000, lat, npr, res, flg, err);
    checks++; if (res !== 16'h8000) $display("FAIL nohab_add_res got=%h exp=8000", res); else passed++;
    run_op(5'd0, 3'd5, 3'd0, 3'd0, 1'b0, 16'h0000, lat, npr, res, flg, err);
    checks++; if (res !== 16'h0000) $display("FAIL nohab_passa_res got=%h exp=0000", res); else passed++;
    checks++; if (flg !== 4'b1000) $display("FAIL nohab_passa_flags got=%b exp=1000", flg); else passed++;
  endtask

  task automatic test_hazard();
    int lat, npr; logic [15:0] res; logic [3:0] flg; logic err;
    run_op(5'd9, 3'd0, 3'd0, 3'd7, 1'b1, 16'h0003, lat, npr, res, flg, err);
    run_op(5'd1, 3'd7, 3'd7, 3'd7, 1'b1, 16'h0000, lat, npr, res, flg, err);
    checks++; if (res !== 16'h0006) $display("FAIL hazard_add1 got=%h exp=0006", res); else passed++;
    run_op(5'd1, 3'd7, 3'd7, 3'd7, 1'b1, 16'h0000, lat, npr, res, flg, err);
    checks++; if (res !== 16'h000C) $display("FAIL hazard_add2 got=%h exp=000c", res); else passed++;
    checks++; if (flg !== 4'b0000) $display("FAIL hazard_flags got=%b exp=0000", flg); else passed++;
  endtask

  task automatic test_back_to_back();
    int npr, lows, lat, npr2, extra; logic [15:0] rs [3]; logic [15:0] res; logic [3:0] flg; logic err;
    npr = 0; lows = 0; extra = 0;
    for (int i = 0; i < 3; i++) rs[i] = '0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 11 && !bus.ocupado) lows++;
      if (bus.pronto) begin
        if (npr < 3) rs[npr] = bus.resultado;
        npr++;
      end
      if (c < 12) begin
        bus.inicio = 1'b1;
        bus.controleOperacao = (c % 4 == 0) ? 5'd9 : 5'd31;
        bus.Sel_SA = 3'(c); bus.Sel_SB = 3'(c + 1);
        bus.Sel_SC = (c % 4 == 0) ? 3'd1 : 3'd6;
        bus.Hab_Escrita = (c % 4 == 0);
        bus.imediato = 16'h0100 + 16'(c);
      end else begin
        bus.inicio = 1'b0;
      end
    end
    repeat (6) begin
      @(negedge clk);
      if (bus.pronto) extra++;
    end
    checks++; if (npr !== 3) $display("FAIL b2b_count got=%0d exp=3", npr); else passed++;
    checks++; if (rs[0] !== 16'h0100) $display("FAIL b2b_op0 got=%h exp=0100", rs[0]); else passed++;
    checks++; if (rs[1] !== 16'h0104) $display("FAIL b2b_op1 got=%h exp=0104", rs[1]); else passed++;
    checks++; if (rs[2] !== 16'h0108) $display("FAIL b2b_op2 got=%h exp=0108", rs[2]); else passed++;
    checks++; if (lows !== 2) $display("FAIL b2b_idle_gaps got=%0d exp=2", lows); else passed++;
    checks++; if (extra !== 0) $display("FAIL b2b_extra_op got=%0d exp=0", extra); else passed++;
    run_op(5'd0, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000, lat, npr2, res, flg, err);
    checks++; if (res !== 16'h0108) $display("FAIL b2b_r1 got=%h exp=0108", res); else passed++;
  endtask

  task automatic test_undefined();
    int lat, npr; logic [15:0] res; logic [3:0] flg; logic err;
    run_op(5'd9, 3'd0, 3'd0, 3'd2, 1'b0, 16'hF00F, lat, npr, res, flg, err);
    checks++; if (flg !== 4'b0100) $display("FAIL undef_pre_flags got=%b exp=0100", flg); else passed++;
    run_op(5'd31, 3'd1, 3'd2, 3'd2, 1'b1, 16'hAAAA, lat, npr, res, flg, err);
    checks++; if (lat !== 4) $display("FAIL undef_latency got=%0d exp=4", lat); else passed++;
    checks++; if (npr !== 1) $display("FAIL undef_pronto_width got=%0d exp=1", npr); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL undef_erro got=%b exp=1", err); else passed++;
    checks++; if (res !== 16'hF00F) $display("FAIL undef_res got=%h exp=f00f", res); else passed++;
    checks++; if (flg !== 4'b0100) $display("FAIL undef_flags got=%b exp=0100", flg); else passed++;
    run_op(5'd0, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0000, lat, npr, res, flg, err);
    checks++; if (res !== 16'h0001) $display("FAIL undef_r2_kept got=%h exp=0001", res); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL undef_next_erro got=%b exp=0", err); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, npr, seen; logic [15:0] res; logic [3:0] flg; logic err;
    seen = 0;
    @(negedge clk);
    bus.controleOperacao = 5'd9; bus.Sel_SA = 3'd0; bus.Sel_SB = 3'd0;
    bus.Sel_SC = 3'd6; bus.Hab_Escrita = 1'b1; bus.imediato = 16'h1234;
    bus.inicio = 1'b1;
    @(posedge clk);
    #1 bus.inicio = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ocupado !== 1'b1) $display("FAIL midrst_busy_before got=%b exp=1", bus.ocupado); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (bus.ocupado !== 1'b0) $display("FAIL midrst_ocupado got=%b exp=0", bus.ocupado); else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.pronto) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL midrst_pronto got=%0d exp=0", seen); else passed++;
    run_op(5'd0, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0000, lat, npr, res, flg, err);
    checks++; if (res !== 16'h0000) $display("FAIL midrst_r6 got=%h exp=0000", res); else passed++;
    checks++; if (flg !== 4'b1000) $display("FAIL midrst_flags got=%b exp=1000", flg); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0;
    reset = 1'b1;
    bus.inicio = 1'b0; bus.controleOperacao = '0;
    bus.Sel_SA = '0; bus.Sel_SB = '0; bus.Sel_SC = '0;
    bus.Hab_Escrita = 1'b0; bus.imediato = '0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_ldi_add();
    test_sub_shl();
    test_hab_escrita();
    test_hazard();
    test_back_to_back();
    test_undefined();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
